// File: rtl/sha1_engine.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sha1_engine: SHA-1 compression with 16-word message buffer, UNROLL rounds   |
// | per clock and feed-forward digest chaining.   Rev 1.0                       |
// +----------------------------------------------------------------------------+
module sha1_engine #(
  parameter int UNROLL = 1
) (
  input  logic         clk,
  input  logic         nrst,
  input  logic         start_i,
  input  logic         first_i,
  input  logic         abort_i,
  input  logic         wr_en_i,
  input  logic [3:0]   wr_addr_i,
  input  logic [31:0]  wr_data_i,
  output logic         busy_o,
  output logic         done_o,
  output logic [159:0] digest_o
);

  if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 4 || UNROLL == 5)) begin : g_bad_unroll
    $error("sha1_engine: UNROLL must be 1, 2, 4 or 5");
  end

  localparam logic [159:0] C_IV = 160'h67452301_EFCDAB89_98BADCFE_10325476_C3D2E1F0;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ROUND = 2'd1, S_FINAL = 2'd2} state_t;

  state_t         state_q, state_d;
  logic [6:0]     t_q, t_d;
  logic [31:0]    a_q, b_q, c_q, d_q, e_q;
  logic [31:0]    a_d, b_d, c_d, d_d, e_d;
  logic [159:0]   digest_q, digest_d;
  logic           done_q, done_d;
  logic [31:0]    w_q [16];
  logic [31:0]    w_d [16];

  logic [31:0]    w_rnd [16];
  logic [31:0]    ra, rb, rc, rd, re, wt, f, k, tmp;
  logic [6:0]     tt;
  logic [3:0]     idx;
  logic           last_round;

  assign last_round = (t_q == 7'(80 - UNROLL));

  // Rounds t..t+UNROLL-1; expanded words are written back into w_rnd so later
  // rounds of the same cycle see them.
  always_comb begin : p_rounds
    w_rnd = w_q;
    ra = a_q; rb = b_q; rc = c_q; rd = d_q; re = e_q;
    wt = '0; f = '0; k = '0; tmp = '0; tt = '0; idx = '0;
    for (int i = 0; i < UNROLL; i++) begin
      tt  = t_q + 7'(i);
      idx = tt[3:0];
      if (tt < 7'd16) begin
        wt = w_rnd[idx];
      end else begin
        tmp = w_rnd[idx + 4'd13] ^ w_rnd[idx + 4'd8] ^ w_rnd[idx + 4'd2] ^ w_rnd[idx];
        wt  = {tmp[30:0], tmp[31]};
      end
      w_rnd[idx] = wt;
      if (tt < 7'd20) begin
        f = (rb & rc) | (~rb & rd);
        k = 32'h5A827999;
      end else if (tt < 7'd40) begin
        f = rb ^ rc ^ rd;
        k = 32'h6ED9EBA1;
      end else if (tt < 7'd60) begin
        f = (rb & rc) | (rb & rd) | (rc & rd);
        k = 32'h8F1BBCDC;
      end else begin
        f = rb ^ rc ^ rd;
        k = 32'hCA62C1D6;
      end
      tmp = {ra[26:0], ra[31:27]} + f + re + k + wt;
      re  = rd;
      rd  = rc;
      rc  = {rb[1:0], rb[31:2]};
      rb  = ra;
      ra  = tmp;
    end
  end

  always_comb begin : p_fsm_next
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_i && !abort_i) state_d = S_ROUND;
      S_ROUND: begin
        if (abort_i)         state_d = S_IDLE;
        else if (last_round) state_d = S_FINAL;
      end
      S_FINAL: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin : p_data_next
    t_d      = t_q;
    a_d      = a_q;
    b_d      = b_q;
    c_d      = c_q;
    d_d      = d_q;
    e_d      = e_q;
    digest_d = digest_q;
    done_d   = 1'b0;
    w_d      = w_q;
    case (state_q)
      S_IDLE: begin
        // A write in the start cycle lands before the block begins.
        if (wr_en_i) w_d[wr_addr_i] = wr_data_i;
        if (start_i && !abort_i) begin
          {a_d, b_d, c_d, d_d, e_d} = first_i ? C_IV : digest_q;
          if (first_i) digest_d = C_IV;
          t_d = '0;
        end
      end
      S_ROUND: begin
        if (!abort_i) begin
          {a_d, b_d, c_d, d_d, e_d} = {ra, rb, rc, rd, re};
          w_d = w_rnd;
          t_d = t_q + 7'(UNROLL);
        end
      end
      S_FINAL: begin
        if (!abort_i) begin
          digest_d = {digest_q[159:128] + a_q, digest_q[127:96] + b_q,
                      digest_q[95:64]   + c_q, digest_q[63:32]  + d_q,
                      digest_q[31:0]    + e_q};
          done_d   = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q  <= S_IDLE;
      t_q      <= '0;
      a_q      <= '0;
      b_q      <= '0;
      c_q      <= '0;
      d_q      <= '0;
      e_q      <= '0;
      digest_q <= C_IV;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      t_q      <= t_d;
      a_q      <= a_d;
      b_q      <= b_d;
      c_q      <= c_d;
      d_q      <= d_d;
      e_q      <= e_d;
      digest_q <= digest_d;
      done_q   <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    w_q <= w_d;
  end

  assign busy_o   = (state_q != S_IDLE);
  assign done_o   = done_q;
  assign digest_o = digest_q;

endmodule
`default_nettype wire
